// File: rtl/line_track_ctrl_pkg.sv
// Shared definitions for the line tracker and the motor PWM block that decodes its mode word.
// Holds the mode encodings, steering state type and default timing constants.
// The motor block imports the same MODE_* constants so both sides agree on the encoding.
package line_track_ctrl_pkg;

  localparam logic [2:0] MODE_FAST  = 3'd0;
  localparam logic [2:0] MODE_SLOW  = 3'd1;
  localparam logic [2:0] MODE_LEFT  = 3'd2;
  localparam logic [2:0] MODE_RIGHT = 3'd3;
  localparam logic [2:0] MODE_STOP  = 3'd4;

  // 0.5 ms of stable samples and 0.5 s of searching at 100 MHz.
  localparam logic [15:0] DEF_STABLE_CYCLES = 16'd50000;
  localparam logic [31:0] DEF_LOST_TIMEOUT  = 32'd50_000_000;

  typedef enum logic [2:0] {
    ST_STRAIGHT,
    ST_SLOW,
    ST_LEFT,
    ST_RIGHT,
    ST_LOST,
    ST_STOP
  } state_t;

  typedef enum logic {
    TURN_LEFT  = 1'b0,
    TURN_RIGHT = 1'b1
  } turn_t;

  // Mode word for a steering state; LOST steers back toward the last seen side.
  function automatic logic [2:0] mode_of(input state_t st, input turn_t last_turn);
    logic [2:0] m;
    m = MODE_STOP;
    case (st)
      ST_STRAIGHT: m = MODE_FAST;
      ST_SLOW:     m = MODE_SLOW;
      ST_LEFT:     m = MODE_LEFT;
      ST_RIGHT:    m = MODE_RIGHT;
      ST_LOST:     m = (last_turn == TURN_LEFT) ? MODE_LEFT : MODE_RIGHT;
      default:     m = MODE_STOP;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/line_track_ctrl_sensor_debounce.sv
// Two-flop synchroniser plus stability counter for a vector of asynchronous inputs.
// Output moves exactly STABLE_CYCLES+2 clocks after a clean input step; shorter glitches are dropped.
// No handshake: samples every clock, output is a plain level.
module sensor_debounce
  import line_track_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH         = 3,
  parameter logic [15:0] STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Count value at which the candidate has been seen STABLE_CYCLES times in a row.
  localparam logic [15:0] CNT_MAX = STABLE_CYCLES - 16'd1;

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [15:0]      cnt_q, cnt_d;

  // Synchronise, compare with the previous sample, and publish once the run is long enough.
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    cnt_d   = cnt_q;
    filt_d  = filt_q;
    if (sync2_q != prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 16'd1;
    end
    if (cnt_d == CNT_MAX) begin
      filt_d = sync2_q;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      filt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = filt_q;

endmodule

// File: rtl/line_track_ctrl.sv
// Line tracker: debounces the IR sensors and runs the steering FSM that feeds the motor PWM block.
// Mode changes STABLE_CYCLES+4 clocks after a clean sensor step; mode/lost are registered from state.
// No backpressure; optional obstacle stop input is enabled by defining OBSTACLE_STOP_EN.
module line_track_ctrl
  import line_track_ctrl_pkg::*;
#(
  parameter logic [15:0] STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter logic [31:0] LOST_TIMEOUT  = DEF_LOST_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [2:0] sensor,
`ifdef OBSTACLE_STOP_EN
  input  logic       obstacle,
`endif
  output logic [2:0] mode,
  output logic       lost,
  output logic [2:0] filt
);

  logic [2:0]  filt_w;
  state_t      state_q, state_d;
  turn_t       turn_q, turn_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic        timed_out_q, timed_out_d;
  logic [2:0]  mode_q, mode_d;
  logic        lost_q, lost_d;
`ifdef OBSTACLE_STOP_EN
  logic        obs1_q, obs1_d;
  logic        obs2_q, obs2_d;
  logic        hold_q, hold_d;
  logic        resume_lost_q, resume_lost_d;
`endif

  sensor_debounce #(
    .WIDTH        (3),
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .din  (sensor),
    .dout (filt_w)
  );

  // Next steering state: en low first, then obstacle, then the filtered sensor pattern.
  always_comb begin
    state_d     = state_q;
    turn_d      = turn_q;
    tcnt_d      = tcnt_q;
    timed_out_d = timed_out_q;
`ifdef OBSTACLE_STOP_EN
    obs1_d        = obstacle;
    obs2_d        = obs1_q;
    hold_d        = 1'b0;
    resume_lost_d = 1'b0;
`endif
    if (!en) begin
      state_d     = ST_STOP;
      tcnt_d      = '0;
      timed_out_d = 1'b0;
`ifdef OBSTACLE_STOP_EN
    end else if (obs2_q) begin
      // Park in STOP with the search timer frozen; remember whether we were searching.
      state_d       = ST_STOP;
      hold_d        = 1'b1;
      resume_lost_d = (state_q == ST_LOST) || (hold_q && resume_lost_q);
`endif
    end else if (filt_w != 3'b000) begin
      // Any visible line wins, including on the cycle the search timer expires.
      timed_out_d = 1'b0;
      case (filt_w)
        3'b101: state_d = ST_SLOW;
        3'b110, 3'b100: begin
          state_d = ST_LEFT;
          turn_d  = TURN_LEFT;
        end
        3'b011, 3'b001: begin
          state_d = ST_RIGHT;
          turn_d  = TURN_RIGHT;
        end
        default: state_d = ST_STRAIGHT;
      endcase
    end else begin
      case (state_q)
        ST_LOST: begin
          if (tcnt_q == LOST_TIMEOUT - 32'd1) begin
            state_d     = ST_STOP;
            timed_out_d = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 32'd1;
          end
        end
        ST_STOP: begin
`ifdef OBSTACLE_STOP_EN
          if (resume_lost_q) begin
            state_d = ST_LOST;
          end
`endif
        end
        default: begin
          state_d = ST_LOST;
          tcnt_d  = '0;
        end
      endcase
    end
  end

  // Output decode from the current state; registered below so it lags the state by one clock.
  always_comb begin
    mode_d = mode_of(state_q, turn_q);
    lost_d = (state_q == ST_LOST) || ((state_q == ST_STOP) && timed_out_q);
`ifdef OBSTACLE_STOP_EN
    if (hold_q) begin
      lost_d = lost_q;
    end
`endif
  end

  // State and output registers, cleared asynchronously to STOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_STOP;
      turn_q        <= TURN_LEFT;
      tcnt_q        <= '0;
      timed_out_q   <= 1'b0;
      mode_q        <= MODE_STOP;
      lost_q        <= 1'b0;
`ifdef OBSTACLE_STOP_EN
      obs1_q        <= 1'b0;
      obs2_q        <= 1'b0;
      hold_q        <= 1'b0;
      resume_lost_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      turn_q        <= turn_d;
      tcnt_q        <= tcnt_d;
      timed_out_q   <= timed_out_d;
      mode_q        <= mode_d;
      lost_q        <= lost_d;
`ifdef OBSTACLE_STOP_EN
      obs1_q        <= obs1_d;
      obs2_q        <= obs2_d;
      hold_q        <= hold_d;
      resume_lost_q <= resume_lost_d;
`endif
    end
  end

  assign mode = mode_q;
  assign lost = lost_q;
  assign filt = filt_w;

endmodule

// File: tb/tb_line_track_ctrl.sv
// Directed plus randomized bench for line_track_ctrl with a behavioural reference model.
// Small timing constants: 4 stable samples, 10-cycle search timeout.
// Obstacle checks are compiled in when OBSTACLE_STOP_EN is defined.
module tb_line_track_ctrl;

  localparam int S  = 4;
  localparam int LT = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] sensor;
  logic [2:0] mode;
  logic       lost;
  logic [2:0] filt;
`ifdef OBSTACLE_STOP_EN
  logic       obstacle;
`endif

  int compared   = 0;
  int mismatched = 0;
  bit use_model  = 1'b1;

  always #5 clk = ~clk;

  line_track_ctrl #(
    .STABLE_CYCLES(16'(S)),
    .LOST_TIMEOUT (32'(LT))
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .sensor  (sensor),
`ifdef OBSTACLE_STOP_EN
    .obstacle(obstacle),
`endif
    .mode    (mode),
    .lost    (lost),
    .filt    (filt)
  );

  // Reference model. Motion is tracked as the mode number it produces (0..3),
  // 4 = halted, 5 = searching for the line.
  logic [2:0] m_s1, m_s2, m_last, m_filt;
  int         m_run;
  int         m_st;
  bit         m_left_last;
  bit         m_timed_out;
  int         m_tc;
  logic [2:0] m_mode;
  logic       m_lost;

  function automatic int steer(input logic [2:0] v);
    case (v)
      3'b010, 3'b111: return 0;
      3'b101:         return 1;
      3'b110, 3'b100: return 2;
      default:        return 3;
    endcase
  endfunction

  task automatic model_edge();
    logic [2:0] cand;
    if (reset) begin
      m_s1 = 3'b000; m_s2 = 3'b000; m_last = 3'b000; m_run = 1; m_filt = 3'b000;
      m_st = 4; m_left_last = 1'b1; m_timed_out = 1'b0; m_tc = 0;
      m_mode = 3'd4; m_lost = 1'b0;
      return;
    end
    // outputs show the motion decided on the previous clock
    m_mode = (m_st == 5) ? (m_left_last ? 3'd2 : 3'd3) : 3'(m_st);
    m_lost = (m_st == 5) || (m_st == 4 && m_timed_out);
    if (!en) begin
      m_st = 4; m_timed_out = 1'b0; m_tc = 0;
    end else if (m_filt != 3'b000) begin
      m_timed_out = 1'b0;
      m_st = steer(m_filt);
      if (m_st == 2) m_left_last = 1'b1;
      if (m_st == 3) m_left_last = 1'b0;
    end else if (m_st == 5) begin
      if (m_tc == LT - 1) begin
        m_st = 4; m_timed_out = 1'b1;
      end else begin
        m_tc++;
      end
    end else if (m_st != 4) begin
      m_st = 5; m_tc = 0;
    end
    // filtered vector follows a run of S identical samples, two clocks behind the pins
    cand = m_s2;
    if (cand == m_last) m_run = (m_run < S) ? m_run + 1 : m_run;
    else m_run = 1;
    m_last = cand;
    if (m_run >= S) m_filt = cand;
    m_s2 = m_s1;
    m_s1 = sensor;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: model follows the edge, DUT sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    if (use_model) begin
      chk("model_mode", 32'(mode), 32'(m_mode));
      chk("model_lost", 32'(lost), 32'(m_lost));
      chk("model_filt", 32'(filt), 32'(m_filt));
    end
  endtask

  initial begin
    int len;
    reset  = 1'b1;
    en     = 1'b1;
    sensor = 3'b000;
`ifdef OBSTACLE_STOP_EN
    obstacle = 1'b0;
`endif
    repeat (3) step();
    chk("reset_mode", 32'(mode), 32'd4);
    chk("reset_lost", 32'(lost), 32'd0);
    chk("reset_filt", 32'(filt), 32'd0);

    // reset release followed by a 010 step: mode 0 exactly 8 clocks later
    reset  = 1'b0;
    sensor = 3'b010;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("startup_filt", 32'(filt), (i >= 6) ? 32'h2 : 32'h0);
      chk("startup_mode", 32'(mode), (i >= 8) ? 32'd0 : 32'd4);
    end

    // 010 -> 110: filt after 6, mode LEFT after 8
    sensor = 3'b110;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("left_filt", 32'(filt), (i >= 6) ? 32'h6 : 32'h2);
      chk("left_mode", 32'(mode), (i >= 8) ? 32'd2 : 32'd0);
    end

    // 3-clock 011 glitch is invisible
    for (int i = 1; i <= 13; i++) begin
      sensor = (i <= 3) ? 3'b011 : 3'b110;
      step();
      chk("glitch_filt", 32'(filt), 32'h6);
      chk("glitch_mode", 32'(mode), 32'd2);
    end

    // RIGHT, then line lost: search right for 10 cycles, then STOP with lost held
    sensor = 3'b001;
    repeat (10) step();
    chk("right_mode", 32'(mode), 32'd3);
    sensor = 3'b000;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("lost_mode", 32'(mode), (i >= 18) ? 32'd4 : 32'd3);
      chk("lost_flag", 32'(lost), (i >= 8) ? 32'd1 : 32'd0);
    end
    sensor = 3'b010;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("recover_mode", 32'(mode), (i >= 8) ? 32'd0 : 32'd4);
      chk("recover_lost", 32'(lost), (i >= 8) ? 32'd0 : 32'd1);
    end

    // filt becomes 001 on the very cycle the search timer expires: RIGHT, never STOP
    sensor = 3'b100;
    repeat (10) step();
    sensor = 3'b000;
    for (int i = 1; i <= 24; i++) begin
      if (i == 11) sensor = 3'b001;
      step();
      chk("race_mode", 32'(mode), (i >= 18) ? 32'd3 : 32'd2);
      chk("race_lost", 32'(lost), (i >= 8 && i <= 17) ? 32'd1 : 32'd0);
    end

    // en dropped during LEFT: STOP two clocks later; re-enable on blank floor stays stopped
    sensor = 3'b110;
    repeat (10) step();
    en = 1'b0;
    step();
    chk("en_drop_1", 32'(mode), 32'd2);
    step();
    chk("en_drop_2", 32'(mode), 32'd4);
    sensor = 3'b000;
    repeat (10) step();
    en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      chk("en_rise_mode", 32'(mode), 32'd4);
      chk("en_rise_lost", 32'(lost), 32'd0);
    end

    // reset in the middle of a right-hand search: timer and last turn start afresh
    sensor = 3'b001;
    repeat (10) step();
    sensor = 3'b000;
    repeat (12) step();
    chk("search_mode", 32'(mode), 32'd3);
    reset = 1'b1;
    #1;
    chk("async_reset_mode", 32'(mode), 32'd4);
    step();
    reset  = 1'b0;
    sensor = 3'b010;
    repeat (10) step();
    sensor = 3'b000;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk("post_reset_search", 32'(mode), (i >= 18) ? 32'd4 : ((i >= 8) ? 32'd2 : 32'd0));
    end

    // randomized sensor patterns, enable drops and occasional resets against the model
    for (int blk = 0; blk < 200; blk++) begin
      len = $urandom_range(1, 24);
      if ($urandom_range(0, 2) == 0) sensor = 3'b000;
      else sensor = 3'($urandom_range(0, 7));
      en    = ($urandom_range(0, 14) != 0);
      reset = ($urandom_range(0, 59) == 0);
      repeat (len) step();
    end
    reset = 1'b0;
    en    = 1'b1;

`ifdef OBSTACLE_STOP_EN
    // 5-cycle obstacle pulse in STRAIGHT: stopped throughout, back to fast 4 clocks after release
    sensor = 3'b010;
    repeat (12) step();
    use_model = 1'b0;
    obstacle  = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      if (i == 6) obstacle = 1'b0;
      step();
      chk("obstacle_mode", 32'(mode), (i >= 4 && i <= 8) ? 32'd4 : 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/line_track_ctrl.md
Name: line_track_ctrl

Overview:
- Upstream stage of the motor PWM block.
- Samples the three IR line sensors and debounces them.
- Runs the steering state machine and issues the registered 3-bit mode word that the motor block decodes into duty cycles.
- Also flags a lost-line condition to the top level for LEDs or seven-segment display.

Parameters:
- STABLE_CYCLES, 16'd50000, consecutive equal samples required before the filtered sensor vector updates (0.5 ms at 100 MHz); legal range 1..65535.
- LOST_TIMEOUT, 32'd50_000_000, cycles spent searching in LOST before giving up to STOP (0.5 s); legal range ≥1.

Ports:
- clk  input  1  100 MHz system clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  run enable from the start switch; level, synchronous to clk
- sensor  input  3  raw IR bits {left, mid, right}; 1 = line seen; asynchronous
- mode  output  3  0 fast, 1 slow, 2 turn left, 3 turn right, 4 stop
- lost  output  1  high while in LOST or in STOP entered by timeout
- filt  output  3  debounced sensor vector, for debug display

Behaviour:
- Reset is asynchronous, active-high, on clk.
- Reset values:
  - sync flops 0
  - filt 3'b000, debounce count 0
  - state STOP, mode 3'd4, lost 0
  - last_turn LEFT, timeout count 0
- Synchroniser: two-flop on each sensor bit.
- Debounce:
  - candidate = synchronised vector.
  - If the candidate differs from the previous sample, clear the count.
  - Otherwise increment the count, saturating.
  - When the count reaches STABLE_CYCLES-1, filt <= candidate.
  - filt changes only after STABLE_CYCLES identical consecutive samples.
  - Glitches shorter than that are never visible.
- State machine: STRAIGHT, SLOW, LEFT, RIGHT, LOST, STOP. The next state is evaluated every cycle from filt.
  - 010 or 111 -> STRAIGHT
  - 101 -> SLOW
  - 110 or 100 -> LEFT; sets last_turn = LEFT
  - 011 or 001 -> RIGHT; sets last_turn = RIGHT
  - 000:
    - from STRAIGHT, SLOW, LEFT or RIGHT -> LOST, with the timeout count cleared
    - from LOST -> stay in LOST
    - from STOP -> stay in STOP
- LOST:
  - Steers toward last_turn: mode 2 or 3.
  - Timeout count increments each cycle.
  - At count == LOST_TIMEOUT-1 -> STOP, with lost held at 1.
  - Any non-000 filt exits LOST per the table above and clears lost.
- STOP after timeout: lost stays 1 until filt becomes non-000 or en falls.
- en low:
  - Next state is STOP.
  - lost is cleared; the timeout count is cleared.
  - en low has priority over all sensor transitions.
- Timing:
  - mode and lost are registered and decoded from the state; one cycle after the state changes.
  - Total latency from a clean sensor pin step to mode change is STABLE_CYCLES+4 clocks, and is fixed.
  - filt changes exactly STABLE_CYCLES+2 clocks after the pin step.
- Simultaneous events: a filt update on the same cycle as the timeout expiring is resolved by the sensor. A non-000 filt wins and the block does not enter STOP.
- Reset mid-search: returns to STOP immediately, with no residual timeout count and last_turn back to LEFT.
- Mode encodings 5..7 are never driven.

Optional Feature:
- Macro: OBSTACLE_STOP_EN.
- Defined:
  - Adds an input port obstacle, 1 bit, from the ultrasonic distance block, synchronised by two flops.
  - While the synchronised obstacle is 1, the next state is STOP with priority just below en low.
  - The timeout count is frozen; lost is unchanged.
  - On release the state machine resumes from filt on the next cycle. If filt is 000, it goes to LOST when the pre-obstacle state was LOST, otherwise it stays in STOP.
- Undefined: no obstacle port and no related logic.

Decomposition:
- Shared package:
  - mode encodings: MODE_FAST=3'd0, MODE_SLOW=3'd1, MODE_LEFT=3'd2, MODE_RIGHT=3'd3, MODE_STOP=3'd4
  - state typedef
  - default STABLE_CYCLES and LOST_TIMEOUT
- The motor block must adopt the same mode constants.
- One sub-module, sensor_debounce: synchroniser plus counter, parameterised by width and STABLE_CYCLES, reusable for the start button.

Test Plan:
- Reset with sensor=010, en=1, STABLE_CYCLES=4 -> mode stays 4, then becomes 0 exactly 8 clocks after reset release. The bench releases reset, then steps the sensor.
- With en=1, STABLE_CYCLES=4, sensor steps 010->110 -> filt=110 after 6 clocks, mode=2 after 8. A 3-clock 011 glitch -> filt and mode unchanged.
- From RIGHT, sensor=000 with LOST_TIMEOUT=10 -> mode=3 and lost=1. Exactly 10 cycles after entering LOST the state goes to STOP: mode=4 with lost still 1. Then sensor=010 -> mode=0, lost=0.
- In LOST, filt becomes 001 on the timeout-expiry cycle -> RIGHT, never STOP.
- en dropped during LEFT -> mode=4 two cycles later. en raised with filt=000 -> stays 4.
- With OBSTACLE_STOP_EN defined and STRAIGHT active:
  - obstacle pulse of 5 cycles -> mode=4 throughout.
  - After release, mode returns to 0 with a fixed 4-clock latency.
